dot_update_queue: RTL

// Sits between the processor's dot-position MMIO writes and the VGA pixel stage; it is the

---
 rtl/dot_update_queue.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/dot_update_queue.sv
// Buffers processor dot-position writes and replays them to the VGA pixel stage only after
// a frame-end pulse, holding each replayed write for one full pixel-clock period.
module dot_update_queue #(
    parameter int NUM_DOTS   = 38,
    parameter int FIFO_DEPTH = 64,
    parameter int HOLD_CYC   = 4,
    parameter int MAX_X      = 639,
    parameter int MAX_Y      = 479
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [31:0] wr_id,
    input  logic [31:0] wr_x,
    input  logic [31:0] wr_y,
    output logic        wr_ready,
    input  logic        frame_end,
    input  logic        clear_flags,
    output logic        dotWren,
    output logic        is_Yloc,
    output logic [31:0] dotID,
    output logic [31:0] dotLoc,
    output logic        busy,
    output logic        frame_tick,
    output logic        overflow,
    output logic        bad_id
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [9:0]    X_LIM     = 10'(MAX_X);
    localparam logic [8:0]    Y_LIM     = 9'(MAX_Y);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, POP, WR_X, WR_Y} state_t;

    typedef struct packed {
        logic [5:0] id;
        logic [9:0] x;
        logic [8:0] y;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        wr_ent;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          id_ok;
    logic          push;
    logic          pop;
    logic          fe_q;
    logic          fe_rise;
    logic          tick_pend;
    state_t        state;
    logic [AW:0]   budget;
    logic [HW-1:0] hold_cnt;
    logic [8:0]    y_hold;
    logic          unused_hi_bits;

    assign unused_hi_bits = ^{wr_x[31:10], wr_y[31:9]};

    // Depth is a power of two, so the count MSB alone marks "full".
    assign full     = count[AW];
    assign wr_ready = ~full;
    assign id_ok    = (wr_id < 32'(NUM_DOTS));
    assign push     = wr_valid & ~full & id_ok;
    assign pop      = (state == POP);
    assign fe_rise  = frame_end & ~fe_q;
    assign head     = mem[rd_ptr];

    always_comb begin
        wr_ent    = '0;
        wr_ent.id = wr_id[5:0];
        wr_ent.x  = (wr_x[9:0] > X_LIM) ? X_LIM : wr_x[9:0];
        wr_ent.y  = (wr_y[8:0] > Y_LIM) ? Y_LIM : wr_y[8:0];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_ent;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A flag being set this cycle takes precedence over clear_flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            bad_id   <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            fe_q <= frame_end;
            if (wr_valid & full) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (wr_valid & ~full & ~id_ok) begin
                bad_id <= 1'b1;
            end else if (clear_flags) begin
                bad_id <= 1'b0;
            end
        end
    end

    // Only the entries present at the frame-end edge are drained (budget snapshot).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            budget     <= '0;
            hold_cnt   <= '0;
            y_hold     <= '0;
            tick_pend  <= 1'b0;
            dotWren    <= 1'b0;
            is_Yloc    <= 1'b0;
            dotID      <= '0;
            dotLoc     <= '0;
            busy       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            tick_pend  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_pend) begin
                        frame_tick <= 1'b1;
                    end
                    if (fe_rise) begin
                        budget <= count;
                        if (count == '0) begin
                            tick_pend <= 1'b1;
                        end else begin
                            state <= POP;
                            busy  <= 1'b1;
                        end
                    end
                end
                POP: begin
                    budget   <= budget - CNT_ONE;
                    y_hold   <= head.y;
                    dotID    <= 32'(head.id);
                    dotLoc   <= 32'(head.x);
                    is_Yloc  <= 1'b0;
                    dotWren  <= 1'b1;
                    hold_cnt <= '0;
                    state    <= WR_X;
                end
                WR_X: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        is_Yloc  <= 1'b1;
                        dotLoc   <= 32'(y_hold);
                        state    <= WR_Y;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                WR_Y: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        dotWren  <= 1'b0;
                        is_Yloc  <= 1'b0;
                        if (budget != '0) begin
                            state <= POP;
                        end else begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_tick <= 1'b1;
                            dotID      <= '0;
                            dotLoc     <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
